// File: rtl/serial_subtractor_ctrl_if.sv
// Handshake/operand bundle for serial_subtractor_ctrl.
// Optional signed-overflow flag is present only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_ctrl_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
`else
  modport master (output start, a, b, bin, input busy, done, diff, bout);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor controller: computes a - b - bin one bit per cycle, LSB first.
// Optional feature macro: SERIAL_SUB_OVF_EN adds a signed-overflow flag (ovf).
//
// state | meaning
// IDLE  | waiting for start; operands captured on acceptance
// SHIFT | one full-subtractor bit per cycle, WIDTH cycles total
// DONE  | result valid, one-cycle done pulse, then back to IDLE
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_r;
  logic             borrow;
  logic             busy_r;
  logic             done_r;
  logic [CW-1:0]    cnt;
  logic             d_bit;
  logic             c_next;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
  logic             ovf_r;
`endif

  // Full-subtractor on the current LSBs; borrow is the carried state
  assign d_bit  = a_sr[0] ^ b_sr[0] ^ borrow;
  assign c_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);

  // Sequencer and datapath; borrow flop doubles as the registered bout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      diff_r <= '0;
      borrow <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            borrow <= bus.bin;
            cnt    <= '0;
            busy_r <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= bus.a[WIDTH-1];
            b_msb  <= bus.b[WIDTH-1];
`endif
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          diff_r <= {d_bit, diff_r[WIDTH-1:1]};
          borrow <= c_next;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          if (cnt == CW'(WIDTH - 1)) begin
            // last bit: d_bit is the result MSB
`ifdef SERIAL_SUB_OVF_EN
            ovf_r  <= (a_msb != b_msb) && (d_bit != a_msb);
`endif
            done_r <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.diff = diff_r;
  assign bus.bout = borrow;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf  = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed bench for serial_subtractor_ctrl: WIDTH=8 vectors plus an exhaustive WIDTH=4 sweep.
module tb_serial_subtractor_ctrl;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  serial_subtractor_ctrl_if #(.WIDTH(8)) b8 ();
  serial_subtractor_ctrl_if #(.WIDTH(4)) b4 ();

  serial_subtractor_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  serial_subtractor_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Run one WIDTH=8 op; inj_cyc>0 pulses a disturbing start in that cycle
  task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic bi, input int inj_cyc, input logic [7:0] exp_d,
                      input logic exp_bo, input logic exp_ovf);
    int lat;
    int pulses;
    @(negedge clk);
    b8.a = av; b8.b = bv; b8.bin = bi; b8.start = 1'b1;
    @(posedge clk); #1;
    b8.start = 1'b0; b8.a = ~av; b8.b = ~bv; b8.bin = ~bi;
    lat = 0; pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (b8.done) begin
        pulses++;
        if (lat == 0) lat = i;
      end
      if (i == 1) chk({tag, "_busy"}, 64'(b8.busy), 64'd1);
      if (i == inj_cyc) begin
        b8.start = 1'b1; b8.a = 8'hFF; b8.b = 8'h00;
      end else begin
        b8.start = 1'b0;
      end
    end
    chk({tag, "_lat"}, 64'(lat), 64'd9);
    chk({tag, "_pulses"}, 64'(pulses), 64'd1);
    chk({tag, "_diff"}, 64'(b8.diff), 64'(exp_d));
    chk({tag, "_bout"}, 64'(b8.bout), 64'(exp_bo));
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, "_ovf"}, 64'(b8.ovf), 64'(exp_ovf));
`else
    if (exp_ovf) begin end
`endif
  endtask

  // Run one WIDTH=4 op and compare against a 5-bit two's-complement reference
  task automatic run4(input logic [3:0] av, input logic [3:0] bv, input logic bi);
    int lat;
    int pulses;
    logic [4:0] ref5;
    ref5 = 5'({1'b0, av} - {1'b0, bv} - {4'b0, bi});
    @(negedge clk);
    b4.a = av; b4.b = bv; b4.bin = bi; b4.start = 1'b1;
    @(posedge clk); #1;
    b4.start = 1'b0; b4.a = ~av; b4.b = ~bv; b4.bin = ~bi;
    lat = 0; pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (b4.done) begin
        pulses++;
        if (lat == 0) lat = i;
      end
    end
    chk($sformatf("w4_%0h_%0h_%0d_res", av, bv, bi), 64'({b4.bout, b4.diff}), 64'(ref5));
    chk($sformatf("w4_%0h_%0h_%0d_lat", av, bv, bi), 64'(lat), 64'd5);
    chk($sformatf("w4_%0h_%0h_%0d_pulses", av, bv, bi), 64'(pulses), 64'd1);
  endtask

  initial begin
    int pulses;
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    b8.start = 1'b0; b8.a = '0; b8.b = '0; b8.bin = 1'b0;
    b4.start = 1'b0; b4.a = '0; b4.b = '0; b4.bin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(b8.busy), 64'd0);
    chk("rst_done", 64'(b8.done), 64'd0);
    chk("rst_diff", 64'(b8.diff), 64'd0);
    chk("rst_bout", 64'(b8.bout), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 64'(b8.busy), 64'd0);

    run8("s05_03", 8'h05, 8'h03, 1'b0, 0, 8'h02, 1'b0, 1'b0);
    run8("s00_01", 8'h00, 8'h01, 1'b0, 0, 8'hFF, 1'b1, 1'b0);
    run8("s10_0F_b", 8'h10, 8'h0F, 1'b1, 0, 8'h00, 1'b0, 1'b0);
    run8("s00_00_b", 8'h00, 8'h00, 1'b1, 0, 8'hFF, 1'b1, 1'b0);
    run8("sFF_FF", 8'hFF, 8'hFF, 1'b0, 0, 8'h00, 1'b0, 1'b0);
    run8("inj_shift", 8'h05, 8'h03, 1'b0, 4, 8'h02, 1'b0, 1'b0);
    run8("inj_done", 8'h05, 8'h03, 1'b0, 9, 8'h02, 1'b0, 1'b0);
    run8("s80_01", 8'h80, 8'h01, 1'b0, 0, 8'h7F, 1'b0, 1'b1);
    run8("s7F_01", 8'h7F, 8'h01, 1'b0, 0, 8'h7E, 1'b0, 1'b0);

    // Reset mid-operation aborts with no done pulse
    @(negedge clk);
    b8.a = 8'hAA; b8.b = 8'h55; b8.bin = 1'b0; b8.start = 1'b1;
    @(posedge clk); #1;
    b8.start = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (b8.done) pulses++;
    end
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(b8.busy), 64'd0);
    chk("abort_diff", 64'(b8.diff), 64'd0);
    chk("abort_done", 64'(b8.done), 64'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("abort_ovf", 64'(b8.ovf), 64'd0);
`endif
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (b8.done) pulses++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (b8.done) pulses++;
    end
    chk("abort_pulses", 64'(pulses), 64'd0);
    chk("abort_idle_busy", 64'(b8.busy), 64'd0);
    run8("post_rst", 8'h05, 8'h03, 1'b0, 0, 8'h02, 1'b0, 1'b0);

    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++)
          run4(4'(ai), 4'(bi), 1'(ci));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
